// File: rtl/two_port_mem_init_bypass.sv
// Two-port RAM (1W/1R) with lane write masks, write-first collision bypass, read-valid strobe and
// a post-reset zero-fill sequencer. `define TWO_PORT_MEM_OUTREG_EN adds an output stage (read latency 2).
module two_port_mem_init_bypass #(
  parameter  int addresses    = 32,
  parameter  int width        = 8,
  parameter  int laneWidth    = 8,
  localparam int addressWidth = (addresses > 1) ? $clog2(addresses) : 1,
  localparam int numLanes     = (width + laneWidth - 1) / laneWidth
) (
  input  logic                    clk,
  input  logic                    resetN,
  output logic                    initDone,
  input  logic [addressWidth-1:0] writeAddress,
  input  logic                    writeEnable,
  input  logic [numLanes-1:0]     writeMask,
  input  logic [width-1:0]        writeData,
  input  logic [addressWidth-1:0] readAddress,
  input  logic                    readEnable,
  output logic [width-1:0]        readData,
  output logic                    readValid
);

  typedef enum logic {S_INIT, S_READY} state_t;

  localparam logic [addressWidth:0]   LP_DEPTH = (addressWidth + 1)'(addresses);
  localparam logic [addressWidth-1:0] LP_LAST  = addressWidth'(addresses - 1);

  if (addresses == 0 || width == 0) begin : g_param_check
    $error("FAIL %m: addresses and width must both be nonzero");
  end

  logic [width-1:0]        r_mem [addresses];
  state_t                  r_state;
  state_t                  w_nextState;
  logic [addressWidth-1:0] r_clrCnt;
  logic [width-1:0]        r_rdData;
  logic                    r_rdValid;

  logic [width-1:0]        w_bitMask;
  logic                    w_wrInRange;
  logic                    w_rdInRange;
  logic                    w_wrFire;
  logic                    w_rdFire;
  logic [width-1:0]        w_rdWord;

  always_comb begin
    w_bitMask = '0;
    for (int b = 0; b < width; b++) begin
      w_bitMask[b] = writeMask[b / laneWidth];
    end
  end

  // Non-power-of-2 depths leave a hole in the address space; those accesses never touch the array.
  assign w_wrInRange = {1'b0, writeAddress} < LP_DEPTH;
  assign w_rdInRange = {1'b0, readAddress} < LP_DEPTH;
  assign w_wrFire    = (r_state == S_READY) && writeEnable && w_wrInRange;
  assign w_rdFire    = (r_state == S_READY) && readEnable;

  always_comb begin
    w_rdWord = '0;
    if (w_rdInRange) begin
      w_rdWord = r_mem[readAddress];
      if (w_wrFire && (writeAddress == readAddress)) begin
        w_rdWord = (w_rdWord & ~w_bitMask) | (writeData & w_bitMask);
      end
    end
  end

  // Array itself is never reset; the sequencer zero-fills it one word per cycle instead.
  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      r_mem[r_clrCnt] <= '0;
    end else if (w_wrFire) begin
      r_mem[writeAddress] <= (r_mem[writeAddress] & ~w_bitMask) | (writeData & w_bitMask);
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_INIT:  if (r_clrCnt == LP_LAST) w_nextState = S_READY;
      S_READY: w_nextState = S_READY;
      default: w_nextState = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state   <= S_INIT;
      r_clrCnt  <= '0;
      r_rdData  <= '0;
      r_rdValid <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      if (r_state == S_INIT) r_clrCnt <= r_clrCnt + 1'b1;
      r_rdValid <= w_rdFire;
      if (w_rdFire) r_rdData <= w_rdWord;
    end
  end

  assign initDone = (r_state == S_READY);

`ifdef TWO_PORT_MEM_OUTREG_EN
  logic [width-1:0] r_outData;
  logic             r_outValid;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_outData  <= '0;
      r_outValid <= 1'b0;
    end else begin
      r_outValid <= r_rdValid;
      if (r_rdValid) r_outData <= r_rdData;
    end
  end

  assign readData  = r_outData;
  assign readValid = r_outValid;
`else
  assign readData  = r_rdData;
  assign readValid = r_rdValid;
`endif

endmodule

// File: tb/tb_two_port_mem_init_bypass.sv
// Directed bench: 32x16 instance (lanes of 8) for clear/mask/collision, 20x8 instance for the address hole.
module tb_two_port_mem_init_bypass;
`ifdef TWO_PORT_MEM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        resetN;
  int          nAssert = 0;
  int          nFail   = 0;

  logic        a_initDone, a_writeEnable, a_readEnable, a_readValid;
  logic [4:0]  a_writeAddress, a_readAddress;
  logic [1:0]  a_writeMask;
  logic [15:0] a_writeData, a_readData;

  logic        b_initDone, b_writeEnable, b_readEnable, b_readValid;
  logic [4:0]  b_writeAddress, b_readAddress;
  logic [0:0]  b_writeMask;
  logic [7:0]  b_writeData, b_readData;

  two_port_mem_init_bypass #(.addresses(32), .width(16), .laneWidth(8)) u_a (
    .clk(clk), .resetN(resetN), .initDone(a_initDone),
    .writeAddress(a_writeAddress), .writeEnable(a_writeEnable), .writeMask(a_writeMask),
    .writeData(a_writeData), .readAddress(a_readAddress), .readEnable(a_readEnable),
    .readData(a_readData), .readValid(a_readValid)
  );

  two_port_mem_init_bypass #(.addresses(20), .width(8), .laneWidth(8)) u_b (
    .clk(clk), .resetN(resetN), .initDone(b_initDone),
    .writeAddress(b_writeAddress), .writeEnable(b_writeEnable), .writeMask(b_writeMask),
    .writeData(b_writeData), .readAddress(b_readAddress), .readEnable(b_readEnable),
    .readData(b_readData), .readValid(b_readValid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic a_write(input logic [4:0] addr, input logic [15:0] dat, input logic [1:0] mask);
    a_writeAddress = addr; a_writeData = dat; a_writeMask = mask; a_writeEnable = 1'b1;
    tick();
    a_writeEnable = 1'b0;
  endtask

  task automatic a_read(input logic [4:0] addr, input logic [15:0] exp, input string tag);
    a_readAddress = addr; a_readEnable = 1'b1;
    tick();
    a_readEnable = 1'b0;
    repeat (LAT - 1) tick();
    check({tag, "_vld"}, 32'(a_readValid), 32'd1);
    check(tag, 32'(a_readData), 32'(exp));
  endtask

  task automatic b_write(input logic [4:0] addr, input logic [7:0] dat);
    b_writeAddress = addr; b_writeData = dat; b_writeMask = 1'b1; b_writeEnable = 1'b1;
    tick();
    b_writeEnable = 1'b0;
  endtask

  task automatic b_read(input logic [4:0] addr, input logic [7:0] exp, input string tag);
    b_readAddress = addr; b_readEnable = 1'b1;
    tick();
    b_readEnable = 1'b0;
    repeat (LAT - 1) tick();
    check({tag, "_vld"}, 32'(b_readValid), 32'd1);
    check(tag, 32'(b_readData), 32'(exp));
  endtask

  initial begin
    resetN = 1'b0;
    a_writeEnable = 1'b0; a_readEnable = 1'b0; a_writeAddress = '0; a_readAddress = '0;
    a_writeMask = '0; a_writeData = '0;
    b_writeEnable = 1'b0; b_readEnable = 1'b0; b_writeAddress = '0; b_readAddress = '0;
    b_writeMask = '0; b_writeData = '0;
    tick(); tick();
    check("rst_initDone", 32'(a_initDone), 32'd0);
    check("rst_readValid", 32'(a_readValid), 32'd0);
    check("rst_readData", 32'(a_readData), 32'd0);

    // First clear, with requests held active that must be ignored.
    resetN = 1'b1;
    a_writeEnable = 1'b1; a_writeMask = 2'b11; a_writeData = 16'hFFFF; a_readEnable = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      check("init1_done", 32'(a_initDone), 32'(i == 32));
      check("init1_vld", 32'(a_readValid), 32'd0);
    end
    a_writeEnable = 1'b0; a_readEnable = 1'b0;

    for (int i = 0; i < 32; i++) a_write(5'(i), {8'hA5, 8'(i + 1)}, 2'b11);

    // Reset again, interrupt the clear after 10 cycles, then let it run to completion.
    resetN = 1'b0; tick(); resetN = 1'b1;
    repeat (10) tick();
    resetN = 1'b0; tick();
    check("midrst_done", 32'(a_initDone), 32'd0);
    check("midrst_dat", 32'(a_readData), 32'd0);
    resetN = 1'b1;
    a_readEnable = 1'b1; a_readAddress = 5'd3;
    for (int i = 1; i <= 32; i++) begin
      tick();
      check("init2_done", 32'(a_initDone), 32'(i == 32));
      check("init2_vld", 32'(a_readValid), 32'd0);
    end
    a_readEnable = 1'b0;

    // Back-to-back sweep: every word must be zero, one per cycle.
    for (int k = 0; k < 32 + LAT - 1; k++) begin
      a_readEnable = (k < 32);
      a_readAddress = 5'(k);
      tick();
      if (k >= LAT - 1) begin
        check("sweep_vld", 32'(a_readValid), 32'd1);
        check("sweep_dat", 32'(a_readData), 32'd0);
      end
    end
    a_readEnable = 1'b0;
    repeat (LAT) tick();
    check("sweep_end_vld", 32'(a_readValid), 32'd0);

    a_write(5'd5, 16'hABCD, 2'b11);
    a_write(5'd5, 16'h1234, 2'b01);
    a_read(5'd5, 16'hAB34, "mask_lo");
    a_write(5'd5, 16'hFFFF, 2'b00);
    a_read(5'd5, 16'hAB34, "mask_none");
    a_write(5'd5, 16'h9900, 2'b10);
    a_read(5'd5, 16'h9934, "mask_hi");

    a_write(5'd7, 16'h00FF, 2'b11);
    a_writeAddress = 5'd7; a_writeData = 16'h1122; a_writeMask = 2'b10; a_writeEnable = 1'b1;
    a_readAddress = 5'd7; a_readEnable = 1'b1;
    tick();
    a_writeEnable = 1'b0; a_readEnable = 1'b0;
    repeat (LAT - 1) tick();
    check("coll_vld", 32'(a_readValid), 32'd1);
    check("coll_dat", 32'(a_readData), 32'h11FF);
    a_read(5'd7, 16'h11FF, "coll_later");

    a_write(5'd3, 16'h005A, 2'b11);
    a_read(5'd3, 16'h005A, "rd3");
    tick();
    check("idle_vld", 32'(a_readValid), 32'd0);
    check("idle_hold", 32'(a_readData), 32'h005A);
    tick();
    check("idle_hold2", 32'(a_readData), 32'h005A);

    check("b_initDone", 32'(b_initDone), 32'd1);
    b_write(5'd19, 8'h77);
    b_write(5'd25, 8'h55);
    b_read(5'd25, 8'h00, "oor_25");
    b_read(5'd19, 8'h77, "b_19");
    b_read(5'd20, 8'h00, "oor_20");

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
